// File: rtl/e_stage_reg_pkg.sv
// Shared MIPS decode constants, Tnew codes and E-stage bundle types.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package e_stage_reg_pkg;

    // Datapath and field widths
    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned MD_CNT_W = 4;

    // Default mult/div busy windows; both must fit in MD_CNT_W bits
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // Canonical bubble: sll $0,$0,0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2a;
    localparam logic [5:0] FN_SLTU  = 6'h2b;

    // Cycles until an instruction's result can be forwarded from E
    typedef enum logic [1:0] {
        TNEW_0 = 2'd0,
        TNEW_1 = 2'd1,
        TNEW_2 = 2'd2
    } tnew_t;

    // Decoder result for one instruction word
    typedef struct packed {
        tnew_t tnew;
        logic  is_mult;
        logic  is_div;
    } dec_t;

    // Everything the ID/EX register holds for one instruction
    typedef struct packed {
        logic [XLEN-1:0]  ir;
        logic [XLEN-1:0]  pc4;
        logic [XLEN-1:0]  rs;
        logic [XLEN-1:0]  rt;
        logic [XLEN-1:0]  ext;
        logic [REG_W-1:0] fwd_addr;
        logic [XLEN-1:0]  fwd_data;
        tnew_t            tnew;
    } e_bundle_t;

endpackage

// File: rtl/e_stage_reg_tnew_decode.sv
// Combinational decode of an instruction word into Tnew and mult/div class.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input every cycle.
module e_stage_reg_tnew_decode
    import e_stage_reg_pkg::*;
(
    input  logic [XLEN-1:0] i_ir,
    output dec_t            o_dec
);

    logic [5:0] w_op;
    logic [5:0] w_funct;

    assign w_op    = i_ir[31:26];
    assign w_funct = i_ir[5:0];

    // Classify the word; the all-zero NOP is checked first because it
    // otherwise looks like an sll and would be tagged as an ALU producer.
    always_comb begin
        o_dec         = '0;
        o_dec.tnew    = TNEW_0;
        o_dec.is_mult = 1'b0;
        o_dec.is_div  = 1'b0;
        if (i_ir != NOP) begin
            case (w_op)
                OP_LW: begin
                    o_dec.tnew = TNEW_2;
                end
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                    o_dec.tnew = TNEW_1;
                end
                OP_RTYPE: begin
                    case (w_funct)
                        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                        FN_AND, FN_OR, FN_XOR, FN_NOR,
                        FN_SLT, FN_SLTU,
                        FN_SLL, FN_SRL, FN_SRA,
                        FN_SLLV, FN_SRLV, FN_SRAV,
                        FN_MFHI, FN_MFLO: begin
                            o_dec.tnew = TNEW_1;
                        end
                        FN_MULT, FN_MULTU: begin
                            o_dec.is_mult = 1'b1;
                        end
                        FN_DIV, FN_DIVU: begin
                            o_dec.is_div = 1'b1;
                        end
                        default: begin
                            o_dec.tnew = TNEW_0;
                        end
                    endcase
                end
                default: begin
                    // jal, branches, stores, jumps: nothing to forward from E
                    o_dec.tnew = TNEW_0;
                end
            endcase
        end
    end

endmodule

// File: rtl/e_stage_reg.sv
// ID/EX pipeline register with bubble insertion, E-stage forwarding tag and mult/div busy window.
// Latency: 1 cycle from D inputs to E outputs; md_busy_out is a pure register decode.
// Backpressure: stall=1 loads a NOP bubble into E; D holds its bundle and E captures it on the first non-stall edge.
// Optional feature macro: E_REG_BUBBLE_CNT_EN adds a saturating bubble counter on bubble_cnt_out.
module e_stage_reg
    import e_stage_reg_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [XLEN-1:0]   IR_D_in,
    input  logic [XLEN-1:0]   PC4_D_in,
    input  logic [XLEN-1:0]   RS_D_in,
    input  logic [XLEN-1:0]   RT_D_in,
    input  logic [XLEN-1:0]   EXT_D_in,
    input  logic [REG_W-1:0]  Forward_Addr_D_in,
    output logic [XLEN-1:0]   IR_E_out,
    output logic [XLEN-1:0]   PC4_E_out,
    output logic [XLEN-1:0]   RS_E_out,
    output logic [XLEN-1:0]   RT_E_out,
    output logic [XLEN-1:0]   EXT_E_out,
    output logic [REG_W-1:0]  Forward_Addr_E_out,
    output logic [XLEN-1:0]   Forward_Data_E_out,
    output logic [1:0]        Tnew_E_out,
    output logic              md_busy_out
`ifdef E_REG_BUBBLE_CNT_EN
    ,
    output logic [XLEN-1:0]   bubble_cnt_out
`endif
);

    localparam logic [MD_CNT_W-1:0] L_MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] L_DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

    dec_t                w_dec;
    e_bundle_t           w_d_bundle;
    e_bundle_t           r_e;
    logic [MD_CNT_W-1:0] r_md_cnt;

    e_stage_reg_tnew_decode u_tnew_decode (
        .i_ir  (IR_D_in),
        .o_dec (w_dec)
    );

    // Assemble the D-side bundle; the jal link value PC+8 is PC4+4, wrapping mod 2^32
    always_comb begin
        w_d_bundle          = '0;
        w_d_bundle.ir       = IR_D_in;
        w_d_bundle.pc4      = PC4_D_in;
        w_d_bundle.rs       = RS_D_in;
        w_d_bundle.rt       = RT_D_in;
        w_d_bundle.ext      = EXT_D_in;
        w_d_bundle.fwd_addr = Forward_Addr_D_in;
        w_d_bundle.fwd_data = PC4_D_in + 32'd4;
        w_d_bundle.tnew     = w_dec.tnew;
    end

    // ID/EX register: capture D, or load an all-zero bubble while D is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_e <= '0;
        end else if (stall) begin
            r_e <= '0;
        end else begin
            r_e <= w_d_bundle;
        end
    end

    // Mult/div busy window: newest captured op reloads, bubbles never load,
    // and the count keeps draining through stalls
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt <= '0;
        end else if (!stall && w_dec.is_mult) begin
            r_md_cnt <= L_MULT_LOAD;
        end else if (!stall && w_dec.is_div) begin
            r_md_cnt <= L_DIV_LOAD;
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - 1'b1;
        end
    end

`ifdef E_REG_BUBBLE_CNT_EN
    logic [XLEN-1:0] r_bubble_cnt;

    // Count inserted bubbles, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bubble_cnt <= '0;
        end else if (stall && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign bubble_cnt_out = r_bubble_cnt;
`endif

    assign IR_E_out           = r_e.ir;
    assign PC4_E_out          = r_e.pc4;
    assign RS_E_out           = r_e.rs;
    assign RT_E_out           = r_e.rt;
    assign EXT_E_out          = r_e.ext;
    assign Forward_Addr_E_out = r_e.fwd_addr;
    assign Forward_Data_E_out = r_e.fwd_data;
    assign Tnew_E_out         = r_e.tnew;
    assign md_busy_out        = (r_md_cnt != '0);

endmodule

// File: tb/tb_e_stage_reg.sv
// Self-checking bench for the ID/EX register: directed corner cases plus randomized traffic vs a reference model.
module tb_e_stage_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] IR_D_in, PC4_D_in, RS_D_in, RT_D_in, EXT_D_in;
    logic [4:0]  Forward_Addr_D_in;
    logic [31:0] IR_E_out, PC4_E_out, RS_E_out, RT_E_out, EXT_E_out;
    logic [4:0]  Forward_Addr_E_out;
    logic [31:0] Forward_Data_E_out;
    logic [1:0]  Tnew_E_out;
    logic        md_busy_out;
`ifdef E_REG_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_out;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] I_LW   = 32'h8C88_0004;
    localparam logic [31:0] I_JAL  = 32'h0C00_0C04;
    localparam logic [31:0] I_MULT = 32'h0085_0018;
    localparam logic [31:0] I_DIV  = 32'h0085_001A;

    e_stage_reg dut (
        .clk                (clk),
        .reset              (reset),
        .stall              (stall),
        .IR_D_in            (IR_D_in),
        .PC4_D_in           (PC4_D_in),
        .RS_D_in            (RS_D_in),
        .RT_D_in            (RT_D_in),
        .EXT_D_in           (EXT_D_in),
        .Forward_Addr_D_in  (Forward_Addr_D_in),
        .IR_E_out           (IR_E_out),
        .PC4_E_out          (PC4_E_out),
        .RS_E_out           (RS_E_out),
        .RT_E_out           (RT_E_out),
        .EXT_E_out          (EXT_E_out),
        .Forward_Addr_E_out (Forward_Addr_E_out),
        .Forward_Data_E_out (Forward_Data_E_out),
        .Tnew_E_out         (Tnew_E_out),
        .md_busy_out        (md_busy_out)
`ifdef E_REG_BUBBLE_CNT_EN
        ,
        .bubble_cnt_out     (bubble_cnt_out)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_ir, m_pc4, m_rs, m_rt, m_ext, m_fdata;
    logic [4:0]  m_faddr;
    logic [1:0]  m_tnew;
    int          m_md_left;
    longint      m_bubbles;

    // Tnew straight from the instruction-class rules
    function automatic logic [1:0] ref_tnew(input logic [31:0] ir);
        logic [5:0] op;
        logic [5:0] fn;
        op = ir[31:26];
        fn = ir[5:0];
        if (ir == 32'h0) return 2'd0;
        if (op == 6'h23) return 2'd2;
        if (op >= 6'h08 && op <= 6'h0f) return 2'd1;
        if (op == 6'h00 && ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2a || fn == 6'h2b ||
                            fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12}))
            return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, c;
        logic [15:0] imm;
        a = 5'($urandom); b = 5'($urandom); c = 5'($urandom | 1); imm = 16'($urandom);
        case ($urandom_range(0, 15))
            0:  return {6'h23, a, b, imm};          // lw
            1:  return {6'h2b, a, b, imm};          // sw
            2:  return {6'h03, 26'($urandom)};      // jal
            3:  return {6'h04, a, b, imm};          // beq
            4:  return {6'h00, a, b, c, 5'd0, 6'h21}; // addu
            5:  return {6'h0d, a, b, imm};          // ori
            6:  return {6'h0f, 5'd0, b, imm};       // lui
            7:  return {6'h08, a, b, imm};          // addi
            8:  return {16'h0000, c, 5'd0, 6'h10};  // mfhi
            9:  return {16'h0000, c, 5'd0, 6'h12};  // mflo
            10: return {6'h00, a, b, 10'd0, 6'h18}; // mult
            11: return {6'h00, a, b, 10'd0, 6'h1b}; // divu
            12: return 32'h0;                       // nop
            13: return {6'h00, a, 15'd0, 6'h08};    // jr
            14: return {6'h00, a, b, 10'd0, 6'h19}; // multu
            default: return {6'h00, a, b, c, 5'd0, 6'h2a}; // slt
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic model_edge();
        logic [5:0] op;
        logic [5:0] fn;
        op = IR_D_in[31:26];
        fn = IR_D_in[5:0];
        if (stall) begin
            {m_ir, m_pc4, m_rs, m_rt, m_ext, m_fdata} = '0;
            m_faddr = '0;
            m_tnew  = '0;
            if (m_bubbles < 64'hFFFF_FFFF) m_bubbles++;
        end else begin
            m_ir = IR_D_in; m_pc4 = PC4_D_in; m_rs = RS_D_in; m_rt = RT_D_in; m_ext = EXT_D_in;
            m_faddr = Forward_Addr_D_in;
            m_fdata = PC4_D_in + 32'd4;
            m_tnew  = ref_tnew(IR_D_in);
        end
        if (!stall && op == 6'h00 && (fn == 6'h18 || fn == 6'h19)) m_md_left = 5;
        else if (!stall && op == 6'h00 && (fn == 6'h1a || fn == 6'h1b)) m_md_left = 10;
        else if (m_md_left > 0) m_md_left--;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [31:0] ir, input logic [31:0] pc4, input logic [4:0] fa);
        stall = s; IR_D_in = ir; PC4_D_in = pc4; Forward_Addr_D_in = fa;
        RS_D_in = $urandom; RT_D_in = $urandom; EXT_D_in = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0);
        tick();
        tick();
        reset = 1'b1;
        m_ir = '0; m_pc4 = '0; m_rs = '0; m_rt = '0; m_ext = '0; m_fdata = '0;
        m_faddr = '0; m_tnew = '0; m_md_left = 0; m_bubbles = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, I_LW, 32'h1234_5678, 5'd9);
        tick();
        n_checks++;
        if ({IR_E_out, PC4_E_out, RS_E_out, RT_E_out, EXT_E_out, Forward_Addr_E_out,
             Forward_Data_E_out, Tnew_E_out, md_busy_out} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got IR=%h PC4=%h FA=%h FD=%h T=%0d busy=%b, want all 0",
                     IR_E_out, PC4_E_out, Forward_Addr_E_out, Forward_Data_E_out, Tnew_E_out, md_busy_out);
        end
`ifdef E_REG_BUBBLE_CNT_EN
        n_checks++;
        if (bubble_cnt_out !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_bubble_cnt: got %0d want 0", bubble_cnt_out);
        end
`endif
        do_reset();
    endtask

    task automatic test_lw_jal();
        drive(1'b0, I_LW, 32'h0000_3004, 5'd8);
        tick();
        n_checks++;
        if ({Tnew_E_out, Forward_Addr_E_out, Forward_Data_E_out, IR_E_out} !== {2'd2, 5'd8, 32'h3008, I_LW}) begin
            n_errors++;
            $display("FAIL lw_capture: got T=%0d FA=%0d FD=%h IR=%h, want T=2 FA=8 FD=00003008 IR=%h",
                     Tnew_E_out, Forward_Addr_E_out, Forward_Data_E_out, IR_E_out, I_LW);
        end
        drive(1'b0, I_JAL, 32'h0000_3010, 5'd31);
        tick();
        n_checks++;
        if ({Tnew_E_out, Forward_Addr_E_out, Forward_Data_E_out, PC4_E_out} !== {2'd0, 5'd31, 32'h3014, 32'h3010}) begin
            n_errors++;
            $display("FAIL jal_capture: got T=%0d FA=%0d FD=%h PC4=%h, want T=0 FA=31 FD=00003014 PC4=00003010",
                     Tnew_E_out, Forward_Addr_E_out, Forward_Data_E_out, PC4_E_out);
        end
    endtask

    task automatic test_stall();
        logic [31:0] rs_hold;
        do_reset();
        drive(1'b1, I_LW, 32'h0000_3004, 5'd8);
        rs_hold = RS_D_in;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({IR_E_out, Forward_Addr_E_out, Tnew_E_out, Forward_Data_E_out, RS_E_out} !== '0) begin
                n_errors++;
                $display("FAIL stall_bubble[%0d]: got IR=%h FA=%0d T=%0d FD=%h RS=%h, want all 0",
                         i, IR_E_out, Forward_Addr_E_out, Tnew_E_out, Forward_Data_E_out, RS_E_out);
            end
        end
`ifdef E_REG_BUBBLE_CNT_EN
        n_checks++;
        if (bubble_cnt_out !== 32'd3) begin
            n_errors++;
            $display("FAIL stall_bubble_cnt: got %0d want 3", bubble_cnt_out);
        end
`endif
        stall = 1'b0;
        tick();
        n_checks++;
        if ({IR_E_out, RS_E_out, Tnew_E_out} !== {I_LW, rs_hold, 2'd2}) begin
            n_errors++;
            $display("FAIL stall_release: got IR=%h RS=%h T=%0d, want IR=%h RS=%h T=2",
                     IR_E_out, RS_E_out, Tnew_E_out, I_LW, rs_hold);
        end
    endtask

    task automatic test_md();
        do_reset();
        drive(1'b0, I_MULT, 32'h100, 5'd0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++;
            if (md_busy_out !== (c <= 5)) begin
                n_errors++;
                $display("FAIL mult_window cycle %0d: got busy=%b want %b", c, md_busy_out, (c <= 5));
            end
            IR_D_in = 32'h0;
        end
        // mult, one NOP, then div reloads at cycle 2 of the window
        drive(1'b0, I_MULT, 32'h200, 5'd0);
        tick();
        IR_D_in = 32'h0;
        tick();
        IR_D_in = I_DIV;
        for (int c = 1; c <= 11; c++) begin
            tick();
            n_checks++;
            if (md_busy_out !== (c <= 10)) begin
                n_errors++;
                $display("FAIL div_reload cycle %0d: got busy=%b want %b", c, md_busy_out, (c <= 10));
            end
            IR_D_in = 32'h0;
        end
        // stall does not freeze a running count
        drive(1'b0, I_MULT, 32'h300, 5'd0);
        tick();
        drive(1'b1, 32'h0, 32'h0, 5'd0);
        for (int c = 2; c <= 6; c++) begin
            tick();
            n_checks++;
            if (md_busy_out !== (c <= 5)) begin
                n_errors++;
                $display("FAIL mult_under_stall cycle %0d: got busy=%b want %b", c, md_busy_out, (c <= 5));
            end
        end
    endtask

    task automatic test_stall_div_wrap();
        do_reset();
        drive(1'b1, I_DIV, 32'h400, 5'd3);
        tick();
        n_checks++;
        if ({md_busy_out, IR_E_out} !== {1'b0, 32'h0}) begin
            n_errors++;
            $display("FAIL stall_div_bubble: got busy=%b IR=%h want busy=0 IR=0", md_busy_out, IR_E_out);
        end
        drive(1'b0, 32'h0, 32'hFFFF_FFFC, 5'd2);
        tick();
        n_checks++;
        if ({Forward_Data_E_out, PC4_E_out, md_busy_out} !== {32'h0, 32'hFFFF_FFFC, 1'b0}) begin
            n_errors++;
            $display("FAIL pc_wrap: got FD=%h PC4=%h busy=%b want FD=00000000 PC4=fffffffc busy=0",
                     Forward_Data_E_out, PC4_E_out, md_busy_out);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b0, I_DIV, 32'h500, 5'd4);
        tick();
        drive(1'b0, I_LW, 32'h504, 5'd6);
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (md_busy_out !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_busy: got %b want 1", md_busy_out);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({IR_E_out, PC4_E_out, RS_E_out, RT_E_out, EXT_E_out, Forward_Addr_E_out,
             Forward_Data_E_out, Tnew_E_out, md_busy_out} !== '0) begin
            n_errors++;
            $display("FAIL async_reset: got IR=%h FA=%0d FD=%h T=%0d busy=%b, want all 0",
                     IR_E_out, Forward_Addr_E_out, Forward_Data_E_out, Tnew_E_out, md_busy_out);
        end
        do_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) == 0), rand_instr(), $urandom, 5'($urandom));
            model_edge();
            tick();
            n_checks++;
            if ({IR_E_out, PC4_E_out, RS_E_out, RT_E_out, EXT_E_out} !== {m_ir, m_pc4, m_rs, m_rt, m_ext}) begin
                n_errors++;
                $display("FAIL rand_bundle[%0d]: got IR=%h PC4=%h want IR=%h PC4=%h", n, IR_E_out, PC4_E_out, m_ir, m_pc4);
            end
            n_checks++;
            if ({Forward_Addr_E_out, Forward_Data_E_out, Tnew_E_out} !== {m_faddr, m_fdata, m_tnew}) begin
                n_errors++;
                $display("FAIL rand_forward[%0d]: got FA=%0d FD=%h T=%0d want FA=%0d FD=%h T=%0d (IR=%h)",
                         n, Forward_Addr_E_out, Forward_Data_E_out, Tnew_E_out, m_faddr, m_fdata, m_tnew, m_ir);
            end
            n_checks++;
            if (md_busy_out !== (m_md_left != 0)) begin
                n_errors++;
                $display("FAIL rand_md_busy[%0d]: got %b want %b", n, md_busy_out, (m_md_left != 0));
            end
`ifdef E_REG_BUBBLE_CNT_EN
            n_checks++;
            if (bubble_cnt_out !== 32'(m_bubbles)) begin
                n_errors++;
                $display("FAIL rand_bubble_cnt[%0d]: got %0d want %0d", n, bubble_cnt_out, m_bubbles);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0);
        test_reset();
        test_lw_jal();
        test_stall();
        test_md();
        test_stall_div_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
